// File: rtl/array_8_pkg.sv
// array_8_pkg: shared definitions for the array_8 request controller.
//   ARRAY_8_ADDR_W / ARRAY_8_DATA_W / ARRAY_8_MASK_W : macro geometry (256 x 86, 2 lanes)
//   ARRAY_8_LANE_W                                   : bits covered by one write-mask bit
//   array_8_state_e                                  : controller FSM state (INIT, RUN)
package array_8_pkg;

  localparam int ARRAY_8_ADDR_W = 8;
  localparam int ARRAY_8_DATA_W = 86;
  localparam int ARRAY_8_MASK_W = 2;
  localparam int ARRAY_8_LANE_W = 43;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } array_8_state_e;

endpackage

// File: rtl/array_8_resp_fifo.sv
// array_8_resp_fifo: generic 2-entry valid/ready FIFO with registered head.
//   clock, reset_n   : clock and asynchronous active-low reset
//   push, push_data  : write one entry (caller guarantees space)
//   pop_ready        : consumer ready; an entry leaves when valid & pop_ready
//   valid, data      : head entry
//   count            : occupancy 0..2, used upstream for read credits
// array_8_resp_fifo_chk: overflow checker bound into the FIFO.
module array_8_resp_fifo
  import array_8_pkg::*;
#(
  parameter int DATA_W = ARRAY_8_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] ent0_r;
  logic [DATA_W-1:0] ent1_r;
  logic [1:0]        count_r;
  logic [DATA_W-1:0] ent0_nx_s;
  logic [DATA_W-1:0] ent1_nx_s;
  logic [1:0]        count_nx_s;
  logic              pop_s;

  assign pop_s = (count_r != 2'd0) & pop_ready;

  // Next-state for the two slots; ent0 is always the head so data is a plain flop.
  always_comb begin
    ent0_nx_s  = ent0_r;
    ent1_nx_s  = ent1_r;
    count_nx_s = count_r;
    case ({push, pop_s})
      2'b10: begin
        if (count_r == 2'd0) begin
          ent0_nx_s = push_data;
        end else begin
          ent1_nx_s = push_data;
        end
        // Saturate: an overflow is caught by the checker, not absorbed silently.
        if (count_r == 2'd2) begin
          count_nx_s = 2'd2;
        end else begin
          count_nx_s = count_r + 2'd1;
        end
      end
      2'b01: begin
        ent0_nx_s  = ent1_r;
        count_nx_s = count_r - 2'd1;
      end
      2'b11: begin
        // Pop implies count >= 1, so occupancy is unchanged.
        if (count_r == 2'd1) begin
          ent0_nx_s = push_data;
        end else begin
          ent0_nx_s = ent1_r;
          ent1_nx_s = push_data;
        end
      end
      default: begin
        count_nx_s = count_r;
      end
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent0_r  <= {DATA_W{1'b0}};
      ent1_r  <= {DATA_W{1'b0}};
      count_r <= 2'd0;
    end else begin
      ent0_r  <= ent0_nx_s;
      ent1_r  <= ent1_nx_s;
      count_r <= count_nx_s;
    end
  end

  assign valid = (count_r != 2'd0);
  assign data  = ent0_r;
  assign count = count_r;

  array_8_resp_fifo_chk u_chk (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop_s),
    .count   (count_r)
  );

endmodule

module array_8_resp_fifo_chk (
  input logic       clock,
  input logic       reset_n,
  input logic       push,
  input logic       pop,
  input logic [1:0] count
);

  // A push into a full FIFO without a simultaneous pop means the credit logic is broken.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && (count == 2'd2)));

endmodule

// File: rtl/array_8_ctrl.sv
// array_8_ctrl: request controller in front of the 256x86 masked single-port macro array_8_ext.
//   clock, reset_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready            : request handshake
//   req_write/addr/wmask/wdata     : request fields (wmask ignored for reads)
//   resp_valid/resp_ready/resp_data: read responses in request order (2-entry FIFO)
//   init_done                      : array ready for traffic
//   sram_*                         : RW0 port of the macro (rdata is one cycle after a read)
// Build option: define ARRAY_8_ZERO_INIT_EN to zero-fill all 256 entries after every reset.
module array_8_ctrl
  import array_8_pkg::*;
#(
  parameter int ADDR_W = ARRAY_8_ADDR_W,
  parameter int DATA_W = ARRAY_8_DATA_W,
  parameter int MASK_W = ARRAY_8_MASK_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

`ifdef ARRAY_8_ZERO_INIT_EN
  localparam array_8_state_e RESET_STATE = INIT;
  localparam logic [ADDR_W-1:0] INIT_LAST = {ADDR_W{1'b1}};
`else
  localparam array_8_state_e RESET_STATE = RUN;
`endif

  array_8_state_e    state_r;
  array_8_state_e    state_nx_s;
  logic              rd_inflight_r;
  logic [1:0]        fifo_count_s;
  logic              pop_s;
  logic [2:0]        occ_s;
  logic              credit_ok_s;
  logic              rd_accept_s;
  logic              req_ready_s;
  logic              init_done_s;
  logic [ADDR_W-1:0] sram_addr_s;
  logic              sram_en_s;
  logic              sram_wmode_s;
  logic [MASK_W-1:0] sram_wmask_s;
  logic [DATA_W-1:0] sram_wdata_s;

`ifdef ARRAY_8_ZERO_INIT_EN
  logic [ADDR_W-1:0] init_cnt_r;
`endif

  // Responses already buffered plus the one still in the macro pipe, less the one leaving now.
  // pop implies fifo_count >= 1, so the subtraction cannot wrap.
  assign pop_s       = resp_valid & resp_ready;
  assign occ_s       = {1'b0, fifo_count_s} + {2'b00, rd_inflight_r} - {2'b00, pop_s};
  assign credit_ok_s = (occ_s < 3'd2);
  assign rd_accept_s = req_valid & req_ready_s & ~req_write;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state plus the macro drive and handshake outputs.
  always_comb begin
    state_nx_s   = state_r;
    req_ready_s  = 1'b0;
    init_done_s  = 1'b0;
    sram_addr_s  = {ADDR_W{1'b0}};
    sram_en_s    = 1'b0;
    sram_wmode_s = 1'b0;
    sram_wmask_s = {MASK_W{1'b0}};
    sram_wdata_s = {DATA_W{1'b0}};
    case (state_r)
      INIT: begin
`ifdef ARRAY_8_ZERO_INIT_EN
        // reset_n gating keeps the macro quiet while reset is held.
        sram_en_s    = reset_n;
        sram_wmode_s = 1'b1;
        sram_wmask_s = {MASK_W{1'b1}};
        sram_wdata_s = {DATA_W{1'b0}};
        sram_addr_s  = init_cnt_r;
        if (init_cnt_r == INIT_LAST) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = INIT;
        end
`else
        state_nx_s = RUN;
`endif
      end
      RUN: begin
        // Writes never need a response slot; reads need a credit.
        req_ready_s  = req_write | credit_ok_s;
        init_done_s  = 1'b1;
        sram_en_s    = req_valid & req_ready_s;
        sram_wmode_s = req_write;
        sram_addr_s  = req_addr;
        sram_wmask_s = req_wmask;
        sram_wdata_s = req_wdata;
        state_nx_s   = RUN;
      end
      default: begin
        state_nx_s = RESET_STATE;
      end
    endcase
  end

`ifdef ARRAY_8_ZERO_INIT_EN
  // Zero-fill address counter, advances once per INIT cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt_r <= {ADDR_W{1'b0}};
    end else if (state_r == INIT) begin
      init_cnt_r <= init_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      init_cnt_r <= init_cnt_r;
    end
  end
`endif

  // Marks the cycle in which the macro presents read data for last cycle's read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_inflight_r <= 1'b0;
    end else begin
      rd_inflight_r <= rd_accept_s;
    end
  end

  array_8_resp_fifo #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_inflight_r),
    .push_data (sram_rdata),
    .pop_ready (resp_ready),
    .valid     (resp_valid),
    .data      (resp_data),
    .count     (fifo_count_s)
  );

  assign req_ready  = req_ready_s;
  assign init_done  = init_done_s;
  assign sram_addr  = sram_addr_s;
  assign sram_en    = sram_en_s;
  assign sram_wmode = sram_wmode_s;
  assign sram_wmask = sram_wmask_s;
  assign sram_wdata = sram_wdata_s;

endmodule

// File: tb/tb_array_8_ctrl.sv
// tb_array_8_ctrl: self-checking bench for array_8_ctrl with a behavioural model of the
// 256x86 masked macro and a response scoreboard. Honours ARRAY_8_ZERO_INIT_EN if defined.
`timescale 1ns/1ps
module tb_array_8_ctrl;

  localparam int AW = 8;
  localparam int DW = 86;
  localparam int MW = 2;
  localparam int LW = 43;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [MW-1:0] req_wmask;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          init_done;
  logic [AW-1:0] sram_addr;
  logic          sram_en;
  logic          sram_wmode;
  logic [MW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  int t0 = 0;
  int first_acc = 0;

  logic [DW-1:0] exp_q[$];
  int            resp_cyc_q[$];
  logic [DW-1:0] ref_mem [256];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  array_8_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wmask  (req_wmask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .init_done  (init_done),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Power-up contents of the macro for entries never written.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [87:0] w;
    w = {11{~a}};
    return w[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < MW; l++) begin
      if (m[l]) r[l*LW +: LW] = wd[l*LW +: LW];
    end
    return r;
  endfunction

  // Macro model: synchronous, read-first, rdata held until the next read.
  logic [DW-1:0] mem_m   [256];
  logic          wrote_m [256] = '{default: 1'b0};
  logic [DW-1:0] rdata_m = '0;

  always @(posedge clock) begin
    if (sram_en === 1'b1) begin
      if (sram_wmode === 1'b1) begin
        mem_m[sram_addr]   <= merge(wrote_m[sram_addr] ? mem_m[sram_addr] : pat(sram_addr),
                                    sram_wdata, sram_wmask);
        wrote_m[sram_addr] <= 1'b1;
      end else begin
        rdata_m <= wrote_m[sram_addr] ? mem_m[sram_addr] : pat(sram_addr);
      end
    end
  end
  assign sram_rdata = rdata_m;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Response monitor: samples mid-cycle, after inputs settle and before the next edge.
  always begin
    @(negedge clock);
    #2;
    if (reset_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      resp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk_b("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        chk("resp_data", resp_data, exp_q.pop_front());
      end
    end
  end

  // Present a request (called at a falling edge), wait for acceptance, update the model.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [MW-1:0] m,
                       input logic [DW-1:0] d, input int max_wait);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    #1;
    while (req_ready !== 1'b1 && w < max_wait) begin
      @(negedge clock);
      #1;
      w++;
    end
    if (req_ready !== 1'b1) begin
      chk_b("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      last_acc = cyc + 1;
      if (wr) ref_mem[a] = merge(ref_mem[a], d, m);
      else    exp_q.push_back(ref_mem[a]);
    end
    @(negedge clock);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_drain(input int max_wait);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < max_wait) begin
      @(negedge clock);
      w++;
    end
    chk_b("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Called at the falling edge where reset is released.
  task automatic wait_init(input string tag);
    int w;
    w = 0;
    #1;
`ifdef ARRAY_8_ZERO_INIT_EN
    chk_b({tag, "_first_en"}, 32'(sram_en), 32'd1);
    chk_b({tag, "_first_wmode"}, 32'(sram_wmode), 32'd1);
    chk_b({tag, "_first_addr"}, 32'(sram_addr), 32'd0);
    chk_b({tag, "_ready_low"}, 32'(req_ready), 32'd0);
    while (init_done !== 1'b1 && w < 400) begin
      @(negedge clock);
      #1;
      w++;
    end
    chk_b({tag, "_cycles"}, 32'(cyc - t0), 32'd256);
    chk_b({tag, "_ready_up"}, 32'(req_ready), 32'd1);
`else
    chk_b({tag, "_done"}, 32'(init_done), 32'd1);
`endif
    @(negedge clock);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wmask  = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
`ifdef ARRAY_8_ZERO_INIT_EN
      ref_mem[a] = '0;
`else
      ref_mem[a] = pat(8'(a));
`endif
    end

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk_b("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, '0);
    chk_b("rst_sram_en", 32'(sram_en), 32'd0);
`ifdef ARRAY_8_ZERO_INIT_EN
    chk_b("rst_init_done", 32'(init_done), 32'd0);
    chk_b("rst_req_ready", 32'(req_ready), 32'd0);
`else
    chk_b("rst_init_done", 32'(init_done), 32'd1);
    chk_b("rst_req_ready", 32'(req_ready), 32'd1);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    t0 = cyc;
    wait_init("init");

    // Read every address back-to-back
    for (int a = 0; a < 256; a++) issue(1'b0, 8'(a), 2'b00, '0, 4);
    idle();
    wait_drain(50);

    // Per-lane write masks
    issue(1'b1, 8'h10, 2'b01, {DW{1'b1}}, 4);
    issue(1'b0, 8'h10, 2'b00, '0, 4);
    issue(1'b1, 8'h20, 2'b10, {DW{1'b1}}, 4);
    issue(1'b0, 8'h20, 2'b00, '0, 4);
    idle();
    wait_drain(20);

    // Streaming reads: one response per cycle, first one two edges after first accept
    resp_cyc_q.delete();
    for (int a = 0; a < 16; a++) begin
      issue(1'b0, 8'(a), 2'b00, '0, 4);
      if (a == 0) first_acc = last_acc;
    end
    idle();
    wait_drain(20);
    chk_b("b2b_count", 32'(resp_cyc_q.size()), 32'd16);
    if (resp_cyc_q.size() == 16) begin
      chk_b("b2b_first_lat", 32'(resp_cyc_q[0] - first_acc), 32'd1);
      chk_b("b2b_span", 32'(resp_cyc_q[15] - resp_cyc_q[0]), 32'd15);
    end

    // Backpressure: two reads fill the credit, third read stalls, a write still goes
    resp_ready = 1'b0;
    issue(1'b0, 8'h40, 2'b00, '0, 4);
    issue(1'b0, 8'h41, 2'b00, '0, 4);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h42;
    #1;
    chk_b("bp_read_stall", 32'(req_ready), 32'd0);
    @(negedge clock);
    #1;
    chk_b("bp_read_stall2", 32'(req_ready), 32'd0);
    chk_b("bp_resp_valid", 32'(resp_valid), 32'd1);
    issue(1'b1, 8'h43, 2'b11, 86'h3_1234_5678_9abc_def0_1234, 0);
    resp_ready = 1'b1;
    issue(1'b0, 8'h42, 2'b00, '0, 4);
    issue(1'b0, 8'h43, 2'b00, '0, 4);
    idle();
    wait_drain(20);

    // Back-to-back hazards on one address
    issue(1'b1, 8'h50, 2'b11, 86'd5, 4);
    issue(1'b0, 8'h50, 2'b00, '0, 4);
    issue(1'b1, 8'h50, 2'b11, 86'd9, 4);
    issue(1'b0, 8'h50, 2'b00, '0, 4);
    idle();
    wait_drain(20);
    chk("hazard_ref", ref_mem[8'h50], 86'd9);

    // Reset with one response buffered and one read in flight
    resp_ready = 1'b0;
    issue(1'b0, 8'h60, 2'b00, '0, 4);
    issue(1'b0, 8'h61, 2'b00, '0, 4);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk_b("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    resp_ready = 1'b1;
    reset_n    = 1'b1;
    t0 = cyc;
`ifdef ARRAY_8_ZERO_INIT_EN
    for (int a = 0; a < 256; a++) ref_mem[a] = '0;
`endif
    wait_init("reinit");
    #1;
    chk_b("rstmid_no_stale", 32'(resp_valid), 32'd0);
    @(negedge clock);
    issue(1'b0, 8'h50, 2'b00, '0, 4);
    idle();
    wait_drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
